// File: rtl/zelda_rom_pkg.sv
// Shared types and widths for the sprite/tile ROM path.
package zelda_rom_pkg;

    localparam int unsigned ROM_ADDR_W = 10;
    localparam int unsigned PAL_IDX_W  = 3;

    typedef enum logic [1:0] {
        REQ_PIXEL = 2'd0,
        REQ_LINK  = 2'd1,
        REQ_ENEMY = 2'd2,
        REQ_HUD   = 2'd3
    } req_id_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } rom_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: scans from i_ptr upward, wrapping at N-1.
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_c
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // First asserted request at or after the pointer wins.
    always_comb begin
        o_gnt_c = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = PTR_W'((32'(i_ptr) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt_c[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among NUM_REQ requesters; pixel fetch
// (requester 0) has absolute priority, the rest are served round-robin.
module sprite_rom_arbiter
    import zelda_rom_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ADDR_W  = ROM_ADDR_W,
    parameter  int unsigned DATA_W  = PAL_IDX_W,
    parameter  int unsigned ROM_LAT = 1,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_q_i,
    output logic                      rvalid_o,
    output logic [ID_W-1:0]           rid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o
);

    localparam int unsigned RR_N  = NUM_REQ - 1;
    localparam int unsigned PTR_W = (RR_N > 1) ? $clog2(RR_N) : 1;

    // r_ptr is the round-robin start as an index into requesters 1..NUM_REQ-1.
    logic [PTR_W-1:0]              r_ptr;
    logic [RR_N-1:0]               w_rr_gnt;
    logic                          w_any_gnt;
    logic [ID_W-1:0]               w_gnt_id;
    logic [ADDR_W-1:0]             r_last_addr;
    logic [ROM_LAT-1:0]            r_pipe_vld;
    logic [ROM_LAT-1:0][ID_W-1:0]  r_pipe_id;

    rr_arbiter #(
        .N (RR_N)
    ) u_rr (
        .i_req   (req_i[NUM_REQ-1:1]),
        .i_ptr   (r_ptr),
        .o_gnt_c (w_rr_gnt)
    );

    // Pixel fetch overrides the round-robin pick; nothing is granted in reset.
    always_comb begin
        gnt_o = '0;
        if (!rst) begin
            if (req_i[0]) begin
                gnt_o[0] = 1'b1;
            end else begin
                gnt_o[NUM_REQ-1:1] = w_rr_gnt;
            end
        end
    end

    // Encode the winner and steer its address; hold the last one when idle.
    always_comb begin
        w_any_gnt = |gnt_o;
        w_gnt_id  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                w_gnt_id = ID_W'(i);
            end
        end
        rom_addr_o = w_any_gnt ? addr_i[32'(w_gnt_id)*ADDR_W +: ADDR_W] : r_last_addr;
    end

    // Advance the pointer past a round-robin winner and remember the issued address.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_last_addr <= '0;
        end else if (w_any_gnt) begin
            r_last_addr <= rom_addr_o;
            if (!gnt_o[0]) begin
                r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : PTR_W'(w_gnt_id);
            end
        end
    end

    // Tag pipeline matching the ROM read latency.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_any_gnt;
            r_pipe_id[0]  <= w_any_gnt ? w_gnt_id : '0;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign rvalid_o = r_pipe_vld[ROM_LAT-1];
    assign rid_o    = r_pipe_id[ROM_LAT-1];
    assign rdata_o  = rvalid_o ? rom_q_i : '0;
    assign busy_o   = |r_pipe_vld;

endmodule
